// File: rtl/ex_mdu_if.sv
// Operand/op bus between the ID/EX pipeline register, hazard unit and the EX-stage MD unit.
// The pipeline side is the master; the MD unit is the slave.
interface ex_mdu_if;
  logic [3:0]  EX_md_op;
  logic [31:0] EX_RD1;
  logic [31:0] EX_RD2;
  logic        ID_is_md;
  logic        md_busy;
  logic        md_start;
  logic        md_stall;
  logic [31:0] md_out;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [1:0]  md_state;

  modport master (
    output EX_md_op, EX_RD1, EX_RD2, ID_is_md,
    input  md_busy, md_start, md_stall, md_out, HI, LO, md_state
  );

  modport slave (
    input  EX_md_op, EX_RD1, EX_RD2, ID_is_md,
    output md_busy, md_start, md_stall, md_out, HI, LO, md_state
  );
endinterface

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: fixed-latency mult/div into HI/LO plus mfhi/mflo/mthi/mtlo.
// md_state exposes the sequencer (0 idle, 1 mult in flight, 2 div in flight).
module ex_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  ex_mdu_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  state_e        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   pending_hi, pending_lo;
  logic          pending_we;

  logic          is_mult, is_div, busy, accept, done;
  logic          mthi_go, mtlo_go;

  // Handshake: EX_md_op in 1..4 acts as valid, !md_busy as ready; an op is consumed on
  // the rising edge where both hold (md_start). Ops offered while busy are dropped, not held.
  assign is_mult = (bus.EX_md_op == OP_MULT) || (bus.EX_md_op == OP_MULTU);
  assign is_div  = (bus.EX_md_op == OP_DIV)  || (bus.EX_md_op == OP_DIVU);
  assign busy    = (state != S_IDLE);
  assign accept  = !busy && (is_mult || is_div);
  assign done    = busy && (cnt == CW'(1));
  assign mthi_go = !busy && (bus.EX_md_op == OP_MTHI);
  assign mtlo_go = !busy && (bus.EX_md_op == OP_MTLO);

  // Arithmetic operands
  logic signed [63:0] a_ext, b_ext, prod_s;
  logic        [63:0] prod_u;
  logic               sgn, a_neg, b_neg, div_zero;
  logic        [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  always_comb begin
    a_ext  = {{32{bus.EX_RD1[31]}}, bus.EX_RD1};
    b_ext  = {{32{bus.EX_RD2[31]}}, bus.EX_RD2};
    prod_s = a_ext * b_ext;
    prod_u = {32'd0, bus.EX_RD1} * {32'd0, bus.EX_RD2};
  end

  // Signed divide runs on magnitudes; 0x80000000 keeps its bit pattern as a magnitude,
  // which makes 0x80000000 / -1 fall out as quotient 0x80000000, remainder 0.
  always_comb begin
    sgn      = (bus.EX_md_op == OP_DIV);
    a_neg    = sgn && bus.EX_RD1[31];
    b_neg    = sgn && bus.EX_RD2[31];
    a_mag    = a_neg ? (32'd0 - bus.EX_RD1) : bus.EX_RD1;
    b_mag    = b_neg ? (32'd0 - bus.EX_RD2) : bus.EX_RD2;
    div_zero = (bus.EX_RD2 == 32'd0);
    b_safe   = div_zero ? 32'd1 : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem      = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  // Sequencer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (is_mult)     state_nxt = S_MUL;
        else if (is_div) state_nxt = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end else if (busy) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Results are captured at accept and only committed to HI/LO when the countdown ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_hi <= 32'd0;
      pending_lo <= 32'd0;
      pending_we <= 1'b0;
    end else if (accept) begin
      if (bus.EX_md_op == OP_MULT) begin
        pending_hi <= prod_s[63:32];
        pending_lo <= prod_s[31:0];
      end else if (bus.EX_md_op == OP_MULTU) begin
        pending_hi <= prod_u[63:32];
        pending_lo <= prod_u[31:0];
      end else begin
        pending_hi <= rem;
        pending_lo <= quot;
      end
      pending_we <= !(is_div && div_zero);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (done) begin
      if (pending_we) begin
        hi_q <= pending_hi;
        lo_q <= pending_lo;
      end
    end else begin
      if (mthi_go) hi_q <= bus.EX_RD1;
      if (mtlo_go) lo_q <= bus.EX_RD1;
    end
  end

  always_comb begin
    bus.md_out = 32'd0;
    if (bus.EX_md_op == OP_MFHI)      bus.md_out = hi_q;
    else if (bus.EX_md_op == OP_MFLO) bus.md_out = lo_q;
  end

  assign bus.md_busy  = busy;
  assign bus.md_start = accept;
  assign bus.md_stall = bus.ID_is_md && (busy || accept);
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;
  assign bus.md_state = state;

  a_start_idle : assert property (@(posedge clk) disable iff (!reset) accept |-> !busy);
  a_cnt_live   : assert property (@(posedge clk) disable iff (!reset) busy |-> (cnt != '0));

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: reset, arithmetic table, busy window, mthi/mtlo, stall, async reset.
module tb_ex_mdu;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  ex_mdu_if mdu_if();

  ex_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mdu_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } vec_t;

  // ---- driver tasks ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    mdu_if.EX_md_op = op;
    mdu_if.EX_RD1   = a;
    mdu_if.EX_RD2   = b;
    #1;
  endtask

  // Issue one op, then count cycles of busy (bounded).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    drive(op, a, b);
    step();
    drive(4'd0, 32'd0, 32'd0);
    cycles = 0;
    while (mdu_if.md_busy === 1'b1 && cycles < 40) begin
      cycles++;
      step();
    end
  endtask

  // ---- tests ----
  task automatic test_reset();
    reset = 1'b0;
    mdu_if.ID_is_md = 1'b0;
    drive(4'd0, 32'd0, 32'd0);
    step();
    step();
    n_vec++; if (mdu_if.md_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", mdu_if.md_busy); end
    n_vec++; if (mdu_if.HI !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want 0", mdu_if.HI); end
    n_vec++; if (mdu_if.LO !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want 0", mdu_if.LO); end
    n_vec++; if (mdu_if.md_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", mdu_if.md_stall); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_mult_window();
    drive(4'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    n_vec++; if (mdu_if.md_start !== 1'b1) begin n_err++; $display("FAIL mult_start: got %b want 1", mdu_if.md_start); end
    step();
    drive(4'd0, 32'd0, 32'd0);
    for (int i = 0; i < MULT_N - 1; i++) begin
      n_vec++; if (mdu_if.md_busy !== 1'b1) begin n_err++; $display("FAIL mult_busy c%0d: got %b want 1", i, mdu_if.md_busy); end
      n_vec++; if (mdu_if.HI !== 32'd0 || mdu_if.LO !== 32'd0) begin n_err++; $display("FAIL mult_early c%0d: got %h_%h want 0_0", i, mdu_if.HI, mdu_if.LO); end
      step();
    end
    n_vec++; if (mdu_if.md_busy !== 1'b1) begin n_err++; $display("FAIL mult_busy_last: got %b want 1", mdu_if.md_busy); end
    step();
    n_vec++; if (mdu_if.md_busy !== 1'b0) begin n_err++; $display("FAIL mult_done_busy: got %b want 0", mdu_if.md_busy); end
    n_vec++; if (mdu_if.HI !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", mdu_if.HI); end
    n_vec++; if (mdu_if.LO !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mult_lo: got %h want fffffffe", mdu_if.LO); end
  endtask

  task automatic test_arith();
    vec_t tbl[13];
    int   cyc;
    tbl[0]  = '{4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, MULT_N};
    tbl[1]  = '{4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MULT_N};
    tbl[2]  = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MULT_N};
    tbl[3]  = '{4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, MULT_N};
    tbl[4]  = '{4'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MULT_N};
    tbl[5]  = '{4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N};
    tbl[6]  = '{4'd3, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, DIV_N};
    tbl[7]  = '{4'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, DIV_N};
    tbl[8]  = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_N};
    tbl[9]  = '{4'd4, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999, DIV_N};
    tbl[10] = '{4'd4, 32'h0000_0007, 32'h0000_0000, 32'h0000_0005, 32'h1999_9999, DIV_N};
    tbl[11] = '{4'd3, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'h1999_9999, DIV_N};
    tbl[12] = '{4'd4, 32'h8000_0000, 32'h0000_0003, 32'h0000_0002, 32'h2AAA_AAAA, DIV_N};
    for (int i = 0; i < 13; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, cyc);
      n_vec++; if (cyc !== tbl[i].n) begin n_err++; $display("FAIL arith%0d_cycles: got %0d want %0d", i, cyc, tbl[i].n); end
      n_vec++; if (mdu_if.HI !== tbl[i].hi) begin n_err++; $display("FAIL arith%0d_hi: got %h want %h", i, mdu_if.HI, tbl[i].hi); end
      n_vec++; if (mdu_if.LO !== tbl[i].lo) begin n_err++; $display("FAIL arith%0d_lo: got %h want %h", i, mdu_if.LO, tbl[i].lo); end
    end
    drive(4'd5, 32'd0, 32'd0);
    n_vec++; if (mdu_if.md_out !== 32'h0000_0002) begin n_err++; $display("FAIL mfhi_out: got %h want 00000002", mdu_if.md_out); end
    drive(4'd6, 32'd0, 32'd0);
    n_vec++; if (mdu_if.md_out !== 32'h2AAA_AAAA) begin n_err++; $display("FAIL mflo_out: got %h want 2aaaaaaa", mdu_if.md_out); end
    drive(4'd0, 32'd0, 32'd0);
  endtask

  task automatic test_move();
    int cyc;
    drive(4'd1, 32'd3, 32'd4);
    step();
    drive(4'd0, 32'd0, 32'd0);
    step();
    drive(4'd7, 32'h0000_1234, 32'd0);
    n_vec++; if (mdu_if.md_start !== 1'b0) begin n_err++; $display("FAIL mthi_busy_start: got %b want 0", mdu_if.md_start); end
    step();
    drive(4'd8, 32'h0000_5678, 32'd0);
    step();
    drive(4'd0, 32'd0, 32'd0);
    cyc = 0;
    while (mdu_if.md_busy === 1'b1 && cyc < 40) begin cyc++; step(); end
    n_vec++; if (mdu_if.HI !== 32'd0) begin n_err++; $display("FAIL mthi_busy_hi: got %h want 00000000", mdu_if.HI); end
    n_vec++; if (mdu_if.LO !== 32'h0000_000C) begin n_err++; $display("FAIL mtlo_busy_lo: got %h want 0000000c", mdu_if.LO); end
    drive(4'd7, 32'h0000_1234, 32'd0);
    n_vec++; if (mdu_if.md_start !== 1'b0) begin n_err++; $display("FAIL mthi_start: got %b want 0", mdu_if.md_start); end
    step();
    drive(4'd5, 32'd0, 32'd0);
    n_vec++; if (mdu_if.md_out !== 32'h0000_1234) begin n_err++; $display("FAIL mthi_mfhi: got %h want 00001234", mdu_if.md_out); end
    n_vec++; if (mdu_if.md_busy !== 1'b0) begin n_err++; $display("FAIL mthi_nobusy: got %b want 0", mdu_if.md_busy); end
    drive(4'd8, 32'h0000_ABCD, 32'd0);
    step();
    drive(4'd6, 32'd0, 32'd0);
    n_vec++; if (mdu_if.md_out !== 32'h0000_ABCD) begin n_err++; $display("FAIL mtlo_mflo: got %h want 0000abcd", mdu_if.md_out); end
    drive(4'd9, 32'hFFFF_FFFF, 32'h0000_0001);
    n_vec++; if (mdu_if.md_out !== 32'd0 || mdu_if.md_start !== 1'b0) begin n_err++; $display("FAIL op9_comb: got out=%h start=%b want 0/0", mdu_if.md_out, mdu_if.md_start); end
    step();
    drive(4'd0, 32'd0, 32'd0);
    n_vec++; if (mdu_if.HI !== 32'h0000_1234 || mdu_if.LO !== 32'h0000_ABCD || mdu_if.md_busy !== 1'b0) begin
      n_err++; $display("FAIL op9_state: got %h_%h busy=%b want 00001234_0000abcd busy=0", mdu_if.HI, mdu_if.LO, mdu_if.md_busy);
    end
  endtask

  task automatic test_stall();
    mdu_if.ID_is_md = 1'b1;
    drive(4'd0, 32'd0, 32'd0);
    n_vec++; if (mdu_if.md_stall !== 1'b0) begin n_err++; $display("FAIL stall_idle: got %b want 0", mdu_if.md_stall); end
    drive(4'd1, 32'd2, 32'd3);
    n_vec++; if (mdu_if.md_stall !== 1'b1) begin n_err++; $display("FAIL stall_start: got %b want 1", mdu_if.md_stall); end
    step();
    drive(4'd0, 32'd0, 32'd0);
    for (int i = 0; i < MULT_N; i++) begin
      n_vec++; if (mdu_if.md_stall !== 1'b1) begin n_err++; $display("FAIL stall_busy c%0d: got %b want 1", i, mdu_if.md_stall); end
      step();
    end
    n_vec++; if (mdu_if.md_stall !== 1'b0 || mdu_if.md_busy !== 1'b0) begin n_err++; $display("FAIL stall_drop: got stall=%b busy=%b want 0/0", mdu_if.md_stall, mdu_if.md_busy); end
    mdu_if.ID_is_md = 1'b0;
    n_vec++; if (mdu_if.HI !== 32'd0 || mdu_if.LO !== 32'd6) begin n_err++; $display("FAIL stall_result: got %h_%h want 00000000_00000006", mdu_if.HI, mdu_if.LO); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    drive(4'd2, 32'd5, 32'd6);
    step();
    drive(4'd0, 32'd0, 32'd0);
    repeat (MULT_N - 1) step();
    drive(4'd1, 32'd7, 32'd8);
    n_vec++; if (mdu_if.md_start !== 1'b0) begin n_err++; $display("FAIL b2b_ignored: got %b want 0", mdu_if.md_start); end
    step();
    n_vec++; if (mdu_if.md_start !== 1'b1 || mdu_if.md_busy !== 1'b0) begin n_err++; $display("FAIL b2b_accept: got start=%b busy=%b want 1/0", mdu_if.md_start, mdu_if.md_busy); end
    n_vec++; if (mdu_if.LO !== 32'h0000_001E) begin n_err++; $display("FAIL b2b_first: got %h want 0000001e", mdu_if.LO); end
    step();
    drive(4'd0, 32'd0, 32'd0);
    cyc = 0;
    while (mdu_if.md_busy === 1'b1 && cyc < 40) begin cyc++; step(); end
    n_vec++; if (cyc !== MULT_N) begin n_err++; $display("FAIL b2b_cycles: got %0d want %0d", cyc, MULT_N); end
    n_vec++; if (mdu_if.HI !== 32'd0 || mdu_if.LO !== 32'h0000_0038) begin n_err++; $display("FAIL b2b_second: got %h_%h want 00000000_00000038", mdu_if.HI, mdu_if.LO); end
  endtask

  task automatic test_reset_mid_div();
    int cyc;
    drive(4'd3, 32'd100, 32'd7);
    step();
    drive(4'd0, 32'd0, 32'd0);
    repeat (3) step();
    reset = 1'b0;
    #1;
    n_vec++; if (mdu_if.md_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", mdu_if.md_busy); end
    n_vec++; if (mdu_if.HI !== 32'd0 || mdu_if.LO !== 32'd0) begin n_err++; $display("FAIL rst_mid_hilo: got %h_%h want 0_0", mdu_if.HI, mdu_if.LO); end
    step();
    step();
    reset = 1'b1;
    repeat (DIV_N + 2) step();
    n_vec++; if (mdu_if.HI !== 32'd0 || mdu_if.LO !== 32'd0 || mdu_if.md_busy !== 1'b0) begin
      n_err++; $display("FAIL rst_no_late: got %h_%h busy=%b want 0_0 busy=0", mdu_if.HI, mdu_if.LO, mdu_if.md_busy);
    end
    run_op(4'd3, 32'd100, 32'd7, cyc);
    n_vec++; if (cyc !== DIV_N) begin n_err++; $display("FAIL rst_after_cycles: got %0d want %0d", cyc, DIV_N); end
    n_vec++; if (mdu_if.HI !== 32'd2 || mdu_if.LO !== 32'd14) begin n_err++; $display("FAIL rst_after_div: got %h_%h want 00000002_0000000e", mdu_if.HI, mdu_if.LO); end
  endtask

  initial begin
    mdu_if.EX_md_op = 4'd0;
    mdu_if.EX_RD1   = 32'd0;
    mdu_if.EX_RD2   = 32'd0;
    mdu_if.ID_is_md = 1'b0;
    test_reset();
    test_mult_window();
    test_arith();
    test_move();
    test_stall();
    test_back_to_back();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
